// File: rtl/mem_access_unit_if.sv
// Request/response bundle between the memory access unit, the EX/MEM
// pipeline and the data-RAM port.
//   in_*  : pipeline access request (valid/ready, load/store type, addr, data)
//   out_* : result back to the pipeline (valid/ready, load data, error)
//   ram_* : variable-latency RAM port (req/gnt request, rvalid response)
// Modports: slave = the access unit, master = the pipeline/RAM side.
interface mem_access_unit_if #(
  parameter int unsigned XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic            in_r_ena;
  logic            in_w_ena;
  logic [2:0]      in_load_type;
  logic [2:0]      in_store_type;
  logic [XLEN-1:0] in_addr;
  logic [XLEN-1:0] in_w_data;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_r_data;
  logic            out_err;

  logic            ram_req;
  logic            ram_gnt;
  logic            ram_we;
  logic [XLEN-1:0] ram_addr;
  logic [XLEN-1:0] ram_w_mask;
  logic [XLEN-1:0] ram_w_data;
  logic            ram_rvalid;
  logic [XLEN-1:0] ram_r_data;

  modport slave (
    input  in_valid, in_r_ena, in_w_ena, in_load_type, in_store_type, in_addr, in_w_data,
    output in_ready,
    output out_valid, out_r_data, out_err,
    input  out_ready,
    output ram_req, ram_we, ram_addr, ram_w_mask, ram_w_data,
    input  ram_gnt, ram_rvalid, ram_r_data
  );

  modport master (
    output in_valid, in_r_ena, in_w_ena, in_load_type, in_store_type, in_addr, in_w_data,
    input  in_ready,
    input  out_valid, out_r_data, out_err,
    output out_ready,
    input  ram_req, ram_we, ram_addr, ram_w_mask, ram_w_data,
    output ram_gnt, ram_rvalid, ram_r_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// Handshaked memory access unit: accepts one load/store from the pipeline,
// issues it on a req/gnt/rvalid RAM port with byte-lane masks, and returns
// sign/zero-extended load data plus an error flag.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - mem_access_unit_if.slave (pipeline in_*/out_* and RAM ram_*)
// Parameters: XLEN (32 or 64), ADDR_LSB (byte-offset bits).
// Optional macro MEM_MISALIGN_TRAP_EN: when defined, misaligned accesses
// return out_err without touching the RAM; when undefined the offset is
// rounded down to the access size and the access proceeds.
module mem_access_unit #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned ADDR_LSB = $clog2(XLEN / 8)
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  localparam int unsigned SHW = ADDR_LSB + 3;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e              state_q, state_d;
  logic                is_load_q, is_load_d;
  logic [2:0]          ld_type_q, ld_type_d;
  logic [ADDR_LSB-1:0] off_q, off_d;
  logic                out_valid_q, out_valid_d;
  logic                out_err_q, out_err_d;
  logic [XLEN-1:0]     out_r_data_q, out_r_data_d;
  logic                ram_req_q, ram_req_d;
  logic                ram_we_q, ram_we_d;
  logic [XLEN-1:0]     ram_addr_q, ram_addr_d;
  logic [XLEN-1:0]     ram_w_mask_q, ram_w_mask_d;
  logic [XLEN-1:0]     ram_w_data_q, ram_w_data_d;

  logic [1:0]          size_c;
  logic [ADDR_LSB-1:0] raw_off_c, size_lsbs_c, off_c;
  logic                noop_c, conflict_c, ld_ill_c, st_ill_c, illegal_c, err_c;
  logic [XLEN-1:0]     size_mask_c, st_mask_c, st_data_c, lane_c, ext_c;
  logic [SHW-1:0]      st_sh_c, ld_sh_c;

  // Ready only in IDLE and never while reset is held.
  assign bus.in_ready = (state_q == IDLE) && !rst;

  // Decode of the presented access (used only at acceptance).
  assign size_c      = bus.in_r_ena ? bus.in_load_type[1:0] : bus.in_store_type[1:0];
  assign raw_off_c   = bus.in_addr[ADDR_LSB-1:0];
  assign size_lsbs_c = ADDR_LSB'((4'd1 << size_c) - 4'd1);
  assign off_c       = raw_off_c & ~size_lsbs_c;
  assign noop_c      = !bus.in_r_ena && !bus.in_w_ena;
  assign conflict_c  = bus.in_r_ena && bus.in_w_ena;
  assign ld_ill_c    = (bus.in_load_type == 3'b111) ||
                       ((XLEN == 32) && ((bus.in_load_type == 3'b011) ||
                                         (bus.in_load_type == 3'b110)));
  assign st_ill_c    = bus.in_store_type[2] ||
                       ((XLEN == 32) && (bus.in_store_type == 3'b011));
  assign illegal_c   = bus.in_r_ena ? ld_ill_c : (bus.in_w_ena && st_ill_c);

`ifdef MEM_MISALIGN_TRAP_EN
  logic misal_c;
  assign misal_c = !noop_c && |(raw_off_c & size_lsbs_c);
  assign err_c   = conflict_c || illegal_c || misal_c;
`else
  assign err_c   = conflict_c || illegal_c;
`endif

  // Store lane placement: size mask shifted to the (size-aligned) byte lane.
  always_comb begin
    size_mask_c = '1;
    case (size_c)
      2'd0:    size_mask_c = XLEN'(8'hFF);
      2'd1:    size_mask_c = XLEN'(16'hFFFF);
      2'd2:    size_mask_c = XLEN'(32'hFFFF_FFFF);
      default: size_mask_c = '1;
    endcase
  end

  assign st_sh_c   = {off_c, 3'b000};
  assign st_mask_c = size_mask_c << st_sh_c;
  assign st_data_c = (bus.in_w_data & size_mask_c) << st_sh_c;

  // Load extraction: bring the addressed lane down, then extend.
  assign ld_sh_c = {off_q, 3'b000};
  assign lane_c  = bus.ram_r_data >> ld_sh_c;

  always_comb begin
    ext_c = lane_c;
    case (ld_type_q)
      3'b000:  ext_c = XLEN'($signed(lane_c[7:0]));
      3'b001:  ext_c = XLEN'($signed(lane_c[15:0]));
      3'b010:  ext_c = XLEN'($signed(lane_c[31:0]));
      3'b100:  ext_c = XLEN'(lane_c[7:0]);
      3'b101:  ext_c = XLEN'(lane_c[15:0]);
      3'b110:  ext_c = XLEN'(lane_c[31:0]);
      default: ext_c = lane_c;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    is_load_d    = is_load_q;
    ld_type_d    = ld_type_q;
    off_d        = off_q;
    out_valid_d  = out_valid_q;
    out_err_d    = out_err_q;
    out_r_data_d = out_r_data_q;
    ram_req_d    = ram_req_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_w_mask_d = ram_w_mask_q;
    ram_w_data_d = ram_w_data_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          is_load_d    = bus.in_r_ena;
          ld_type_d    = bus.in_load_type;
          off_d        = off_c;
          out_err_d    = err_c;
          out_r_data_d = '0;
          if (noop_c || err_c) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else begin
            state_d      = REQ;
            ram_req_d    = 1'b1;
            ram_we_d     = bus.in_w_ena;
            ram_addr_d   = {bus.in_addr[XLEN-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
            ram_w_mask_d = bus.in_w_ena ? st_mask_c : '0;
            ram_w_data_d = bus.in_w_ena ? st_data_c : '0;
          end
        end
      end
      REQ: begin
        if (bus.ram_gnt) begin
          ram_req_d    = 1'b0;
          ram_we_d     = 1'b0;
          ram_addr_d   = '0;
          ram_w_mask_d = '0;
          ram_w_data_d = '0;
          if (is_load_q) begin
            state_d = WAIT;
          end else begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (bus.ram_rvalid) begin
          out_r_data_d = ext_c;
          out_valid_d  = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      is_load_q    <= 1'b0;
      ld_type_q    <= '0;
      off_q        <= '0;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      out_r_data_q <= '0;
      ram_req_q    <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_w_mask_q <= '0;
      ram_w_data_q <= '0;
    end else begin
      state_q      <= state_d;
      is_load_q    <= is_load_d;
      ld_type_q    <= ld_type_d;
      off_q        <= off_d;
      out_valid_q  <= out_valid_d;
      out_err_q    <= out_err_d;
      out_r_data_q <= out_r_data_d;
      ram_req_q    <= ram_req_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_w_mask_q <= ram_w_mask_d;
      ram_w_data_q <= ram_w_data_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_err    = out_err_q;
  assign bus.out_r_data = out_r_data_q;
  assign bus.ram_req    = ram_req_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_w_mask = ram_w_mask_q;
  assign bus.ram_w_data = ram_w_data_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised, handshaked successor of the single-cycle memory stage.
- Sits between EX/MEM pipeline registers and the data-RAM port, and drives a variable-latency request/grant/response interface.
- Generates byte-lane write masks and data for stores, and extracts and sign/zero-extends load data.
- Generalised to XLEN 32/64, with misalignment and illegal-size detection.

Parameters:
- XLEN, 64, data/address width; legal values 32 or 64.
- ADDR_LSB, $clog2(XLEN/8), number of byte-offset address bits (3 for XLEN 64, 2 for XLEN 32).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  pipeline presents an access
- in_ready  out  1  unit can accept an access
- in_r_ena  in  1  load
- in_w_ena  in  1  store
- in_load_type  in  3  000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu
- in_store_type  in  3  000 sb, 001 sh, 010 sw, 011 sd
- in_addr  in  XLEN  byte address
- in_w_data  in  XLEN  store data, right-aligned
- out_valid  out  1  result available
- out_ready  in  1  pipeline consumes result
- out_r_data  out  XLEN  extended load data; 0 for stores and no-ops
- out_err  out  1  misaligned or illegal access
- ram_req  out  1  request to RAM
- ram_gnt  in  1  RAM accepts request
- ram_we  out  1  1 = write
- ram_addr  out  XLEN  in_addr with low ADDR_LSB bits cleared
- ram_w_mask  out  XLEN  bit-granular mask (0xFF per written byte lane)
- ram_w_data  out  XLEN  store data shifted to its lane
- ram_rvalid  in  1  read data valid
- ram_r_data  in  XLEN  full aligned word

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: FSM in IDLE. All registered outputs are 0: out_valid, out_r_data, out_err, ram_req, ram_we, ram_addr, ram_w_mask, ram_w_data. in_ready is 0 while rst is high.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - in_ready = 1.
  - Accept on in_valid & in_ready and latch all in_* fields.
  - Next state is DONE (no RAM request) when: both r_ena and w_ena are 0 (no-op, data 0, err 0); or both are 1 (err 1); or the access is misaligned/illegal (err 1).
  - Otherwise next state is REQ; ram_req is asserted from the next cycle.
- Misaligned access: address not a multiple of access size (h: addr[0]; w: addr[1:0]; d: addr[2:0]).
- Illegal access: ld, lwu or sd when XLEN = 32; load_type 111; store_type 1xx.
- REQ:
  - ram_req = 1; ram_we, ram_addr, ram_w_mask and ram_w_data are held stable until ram_gnt.
  - On gnt: a store goes to DONE; a load goes to WAIT.
  - ram_rvalid is ignored in REQ.
- WAIT: on ram_rvalid, capture the extended lane (sign for lb/lh/lw; zero for lbu/lhu/lwu; ld passes through) into out_r_data, then go to DONE.
- DONE:
  - out_valid = 1; out_r_data and out_err are held.
  - On out_ready, clear out_valid and go to IDLE. in_ready goes high the cycle after.
  - No back-to-back acceptance in the DONE cycle.
- Minimum latency (load, gnt and rvalid both immediate):
  - accept at cycle 0;
  - ram_req at cycle 1 (gnt at 1);
  - rvalid at cycle 2;
  - out_valid at cycle 3.
- Minimum store latency: out_valid at cycle 2.
- Store lane placement:
  - sb: mask 0xFF << 8*addr[ADDR_LSB-1:0];
  - sh: 0xFFFF << 16*half index;
  - sw: 0xFFFFFFFF << 32*addr[2] (64-bit only);
  - sd: all ones.
  - ram_w_mask and ram_w_data are 0 whenever ram_we = 0.
- Reset mid-operation: the next edge returns to IDLE and clears ram_req and out_valid. An outstanding RAM response after reset is ignored. The RAM tolerates an abandoned request.
- in_* inputs are sampled only at acceptance; later changes have no effect.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: misaligned accesses set out_err = 1, issue no RAM request, and write nothing.
- Undefined:
  - Misalignment is not checked.
  - The access proceeds with the offset truncated to the access size (addr rounded down to a size multiple), matching legacy behaviour.
  - out_err reports only illegal-size and r&w conflicts.

Test Plan:
- XLEN=64, lb at addr 0x1003, ram_r_data 0x0000_0000_8000_0000, gnt and rvalid immediate -> out_valid at cycle 3, out_r_data 0xFFFF_FFFF_FFFF_FF80, out_err 0.
- sh at addr 0x2006, w_data 0x1234, gnt delayed 4 cycles -> ram_req held for 5 cycles with addr 0x2000, mask 0xFFFF_0000_0000_0000, data 0x1234_0000_0000_0000 stable; out_valid 1 cycle after gnt.
- lwu at addr 0x3004, ram_r_data 0xDEAD_BEEF_0000_0001, rvalid 3 cycles after gnt, out_ready held low 2 cycles -> out_r_data 0x0000_0000_DEAD_BEEF, out_valid held, in_ready 0 until consumed.
- With MEM_MISALIGN_TRAP_EN: lw at 0x4002 -> no ram_req, out_valid at cycle 1, out_err 1. Without the macro: ram_req issued, addr 0x4000, lower word returned.
- XLEN=32: sd at 0x0 -> out_err 1, no ram_req. r_ena=w_ena=1 -> out_err 1.
- rst asserted in WAIT, then rvalid pulsed -> next cycle all outputs 0, state IDLE, stale response produces no out_valid.
